prog_loader: RTL and testbench

Program loader for the CPU's instruction memory: the write-side counterpart to the instruction fetch path. Accepts a byte stream over a valid/ready handshake, assembles big-endian 16-bit instructions, and writes them to a writable program memory at consecutive even addresses (PC steps by 2). Holds the CPU in reset while loading and releases it when the image is complete.

---
 rtl/prog_loader_pkg.sv | 16 +
 rtl/prog_loader.sv | 104 ++++++++++
 tb/tb_prog_loader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and the instruction fetch path:
// instruction geometry and the loader FSM state encodings.
package prog_loader_pkg;

   localparam int INSTR_W     = 16;
   localparam int INSTR_BYTES = 2;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LEN_HI = 3'd1;
   localparam logic [2:0] ST_LEN_LO = 3'd2;
   localparam logic [2:0] ST_DAT_HI = 3'd3;
   localparam logic [2:0] ST_DAT_LO = 3'd4;
   localparam logic [2:0] ST_WRITE  = 3'd5;
   localparam logic [2:0] ST_DONE   = 3'd6;

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: takes a 16-bit count then big-endian instructions,
// writes them to program memory at consecutive even addresses, holds the CPU meanwhile.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter int          ADDR_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [7:0]         rx_data,
   input  logic               rx_valid,
   output logic               rx_ready,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [INSTR_W-1:0] mem_wdata,
   output logic               busy,
   output logic               done,
   output logic               cpu_hold
);

   logic [2:0]         r_state;
   logic [15:0]        r_count;
   logic [15:0]        r_idx;
   logic [7:0]         r_hi;
   logic [ADDR_W-1:0]  r_addr;
   logic [INSTR_W-1:0] r_wdata;

   logic               w_ready;
   logic               w_accept;
   logic               w_last;
   logic [ADDR_W-1:0]  w_addr_next;

   assign w_ready  = (r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) ||
                     (r_state == ST_DAT_HI) || (r_state == ST_DAT_LO);
   assign w_accept = rx_valid && w_ready;
   assign w_last   = (r_idx == (r_count - 16'd1));

   // Address wraps silently modulo 2^ADDR_W.
   assign w_addr_next = ADDR_W'(BASE_ADDR) + ADDR_W'(r_idx * INSTR_BYTES);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_idx   <= '0;
         r_hi    <= '0;
         r_addr  <= ADDR_W'(BASE_ADDR);
         r_wdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) r_state <= ST_LEN_HI;
            end
            ST_LEN_HI: begin
               if (w_accept) begin
                  r_count[15:8] <= rx_data;
                  r_state       <= ST_LEN_LO;
               end
            end
            ST_LEN_LO: begin
               if (w_accept) begin
                  r_count[7:0] <= rx_data;
                  r_idx        <= '0;
                  r_state      <= ({r_count[15:8], rx_data} == 16'd0) ? ST_DONE : ST_DAT_HI;
               end
            end
            ST_DAT_HI: begin
               if (w_accept) begin
                  r_hi    <= rx_data;
                  r_state <= ST_DAT_LO;
               end
            end
            ST_DAT_LO: begin
               // Address and word are registered here so they are stable through WRITE.
               if (w_accept) begin
                  r_wdata <= {r_hi, rx_data};
                  r_addr  <= w_addr_next;
                  r_state <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (w_last) begin
                  r_state <= ST_DONE;
               end else begin
                  r_idx   <= r_idx + 16'd1;
                  r_state <= ST_DAT_HI;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign rx_ready  = w_ready;
   assign mem_we    = (r_state == ST_WRITE);
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign busy      = w_ready || (r_state == ST_WRITE);
   assign done      = (r_state == ST_DONE);
   assign cpu_hold  = (r_state != ST_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: two instances (BASE 0 and BASE FFFE) share one
// stimulus stream; write strobes are logged per instance on the rising edge.
module tb_prog_loader;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;

   logic        rx_ready0, mem_we0, busy0, done0, cpu_hold0;
   logic [15:0] mem_addr0, mem_wdata0;
   logic        rx_ready1, mem_we1, busy1, done1, cpu_hold1;
   logic [15:0] mem_addr1, mem_wdata1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int wr0    = 0;
   int wr1    = 0;
   logic [15:0] log_addr0 [0:63];
   logic [15:0] log_data0 [0:63];

   prog_loader #(.BASE_ADDR(16'h0000), .ADDR_W(16)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
      .busy(busy0), .done(done0), .cpu_hold(cpu_hold0)
   );

   prog_loader #(.BASE_ADDR(16'hFFFE), .ADDR_W(16)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .busy(busy1), .done(done1), .cpu_hold(cpu_hold1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we0) begin
         log_addr0[wr0[5:0]] <= mem_addr0;
         log_data0[wr0[5:0]] <= mem_wdata0;
         wr0 <= wr0 + 1;
      end
      if (mem_we1) wr1 <= wr1 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the accepting rising edge.
   task automatic send_byte(input logic [7:0] b, input int gaps);
      int n;
      for (int g = 0; g < gaps; g++) begin
         rx_valid = 1'b0;
         rx_data  = 8'($urandom);
         @(negedge clk);
      end
      rx_valid = 1'b1;
      rx_data  = b;
      n = 0;
      while (!rx_ready0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("handshake_timeout", {31'd0, (n < 50)}, 32'd1);
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int base_wr;
      int t_len;
      int t_wr;
      int n;
      logic [7:0] stream [0:7];
      stream[0] = 8'h00; stream[1] = 8'h03; stream[2] = 8'h51; stream[3] = 8'h11;
      stream[4] = 8'h52; stream[5] = 8'h22; stream[6] = 8'h80; stream[7] = 8'h13;

      rst = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

      // Reset
      repeat (2) @(negedge clk);
      chk("rst_rx_ready", rx_ready0, 1'b0);
      chk("rst_mem_we", mem_we0, 1'b0);
      chk("rst_mem_addr", mem_addr0, 16'h0000);
      chk("rst_mem_wdata", mem_wdata0, 16'h0000);
      chk("rst_busy", busy0, 1'b0);
      chk("rst_done", done0, 1'b0);
      chk("rst_cpu_hold", cpu_hold0, 1'b1);
      chk("rst_mem_addr_b1", mem_addr1, 16'hFFFE);
      rst = 1'b1;
      rx_valid = 1'b1;
      rx_data = 8'hA5;
      repeat (3) @(negedge clk);
      chk("idle_rx_ready", rx_ready0, 1'b0);
      chk("idle_busy", busy0, 1'b0);
      chk("idle_cpu_hold", cpu_hold0, 1'b1);
      chk("idle_no_writes", wr0, 0);
      rx_valid = 1'b0;

      // Nominal load, valid held high
      pulse_start();
      t_len = cyc;
      chk("nom_len_hi_ready", rx_ready0, 1'b1);
      chk("nom_busy", busy0, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(stream[i], 0);
      chk("nom_w0_we", mem_we0, 1'b1);
      chk("nom_w0_addr", mem_addr0, 16'h0000);
      chk("nom_w0_data", mem_wdata0, 16'h5111);
      chk("nom_w0_latency", cyc - t_len, 4);
      t_wr = cyc;
      send_byte(stream[4], 0);
      send_byte(stream[5], 0);
      chk("nom_w1_we", mem_we0, 1'b1);
      chk("nom_w1_addr", mem_addr0, 16'h0002);
      chk("nom_w1_data", mem_wdata0, 16'h5222);
      chk("nom_w1_spacing", cyc - t_wr, 3);
      t_wr = cyc;
      send_byte(stream[6], 0);
      send_byte(stream[7], 0);
      chk("nom_w2_addr", mem_addr0, 16'h0004);
      chk("nom_w2_data", mem_wdata0, 16'h8013);
      chk("nom_w2_spacing", cyc - t_wr, 3);
      @(negedge clk);
      chk("nom_done", done0, 1'b1);
      chk("nom_cpu_hold", cpu_hold0, 1'b0);
      chk("nom_busy_end", busy0, 1'b0);
      chk("nom_we_end", mem_we0, 1'b0);
      chk("nom_addr_hold", mem_addr0, 16'h0004);
      chk("nom_session_len", cyc - t_len, 11);
      chk("nom_write_count", wr0, 3);

      // Zero count
      pulse_start();
      chk("zero_done_cleared", done0, 1'b0);
      chk("zero_cpu_hold", cpu_hold0, 1'b1);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      chk("zero_done", done0, 1'b1);
      chk("zero_busy", busy0, 1'b0);
      chk("zero_no_writes", wr0, 3);

      // Backpressure with junk data and a stray start pulse
      base_wr = wr0;
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         send_byte(stream[i], $urandom_range(0, 3));
         if (i == 4) begin
            pulse_start();
            chk("bp_start_ignored", busy0, 1'b1);
         end
      end
      n = 0;
      while (!done0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("bp_done", done0, 1'b1);
      chk("bp_write_count", wr0 - base_wr, 3);
      chk("bp_w0_addr", log_addr0[base_wr[5:0]], 16'h0000);
      chk("bp_w0_data", log_data0[base_wr[5:0]], 16'h5111);
      chk("bp_w1_addr", log_addr0[6'(base_wr + 1)], 16'h0002);
      chk("bp_w1_data", log_data0[6'(base_wr + 1)], 16'h5222);
      chk("bp_w2_addr", log_addr0[6'(base_wr + 2)], 16'h0004);
      chk("bp_w2_data", log_data0[6'(base_wr + 2)], 16'h8013);

      // Reset mid-load
      base_wr = wr0;
      pulse_start();
      for (int i = 0; i < 4; i++) send_byte(stream[i], 0);
      chk("rml_w0_we", mem_we0, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("rml_busy", busy0, 1'b0);
      chk("rml_rx_ready", rx_ready0, 1'b0);
      chk("rml_cpu_hold", cpu_hold0, 1'b1);
      chk("rml_done", done0, 1'b0);
      rx_valid = 1'b1;
      rx_data = 8'h52;
      repeat (4) @(negedge clk);
      rx_valid = 1'b0;
      chk("rml_no_more_writes", wr0 - base_wr, 1);
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      send_byte(8'hAB, 0);
      send_byte(8'hCD, 0);
      chk("rml_fresh_we", mem_we0, 1'b1);
      chk("rml_fresh_addr", mem_addr0, 16'h0000);
      chk("rml_fresh_data", mem_wdata0, 16'hABCD);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      chk("rml_fresh_addr2", mem_addr0, 16'h0002);
      @(negedge clk);
      chk("rml_fresh_done", done0, 1'b1);

      // Address wrap on the FFFE-based instance
      base_wr = wr1;
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      send_byte(8'hAA, 0);
      send_byte(8'h55, 0);
      chk("wrap_w0_we", mem_we1, 1'b1);
      chk("wrap_w0_addr", mem_addr1, 16'hFFFE);
      chk("wrap_w0_data", mem_wdata1, 16'hAA55);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      chk("wrap_w1_addr", mem_addr1, 16'h0000);
      chk("wrap_w1_data", mem_wdata1, 16'h1234);
      @(negedge clk);
      chk("wrap_done", done1, 1'b1);
      chk("wrap_cpu_hold", cpu_hold1, 1'b0);
      chk("wrap_write_count", wr1 - base_wr, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
